// File: rtl/lutram_test_pkg.sv
// Shared types and snapshot layout for the LUTRAM posedge/negedge write checker.
package lutram_test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2
   } state_t;

   typedef enum logic {
      TGT_POS = 1'b0,
      TGT_NEG = 1'b1
   } target_t;

   // Snapshot field slots, each CNT_W bits wide, LSB first.
   localparam int unsigned SNAP_CHK_POS  = 0;
   localparam int unsigned SNAP_CHK_NEG  = 1;
   localparam int unsigned SNAP_FAIL_POS = 2;
   localparam int unsigned SNAP_FAIL_NEG = 3;
   localparam int unsigned SNAP_FIELDS   = 4;

   localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/lutram_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit, synchronous active-low reset.
module lutram_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d_i};
      end
   end

   assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/lutram_edge_checker.sv
// Monitors JTAG-driven LUTRAM writes, predicts both RAM bits and checks SPO after a
// settle delay; results are kept as sticky flags and a shiftable counter snapshot.
module lutram_edge_checker
   import lutram_test_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8,
   parameter logic        INIT_VAL      = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       wclk_i,
   input  logic       we_i,
   input  logic       di_i,
   input  logic       spo_pos_i,
   input  logic       spo_neg_i,
   input  logic       clear_i,
   input  logic       cap_i,
   input  logic       shift_i,
   input  logic       sdi_i,
   output logic       sdo_o,
   output logic [1:0] fail_o,
   output logic       busy_o
);

   localparam int unsigned SNAP_W  = SNAP_FIELDS * CNT_W;
   localparam int unsigned N_ASYNC = 5;

   logic [N_ASYNC-1:0] w_async;
   logic [N_ASYNC-1:0] w_synced;
   logic               w_wclk_s;
   logic               w_we_s;
   logic               w_di_s;
   logic               w_spo_pos_s;
   logic               w_spo_neg_s;
   logic               w_rise;
   logic               w_fall;
   logic [SNAP_W-1:0]  w_snap;

   logic                r_wclk_d;
   state_t              r_state;
   target_t             r_target;
   logic [SETTLE_W-1:0] r_settle_cnt;
   logic                r_exp_pos;
   logic                r_exp_neg;
   logic [CNT_W-1:0]    r_chk_pos;
   logic [CNT_W-1:0]    r_chk_neg;
   logic [CNT_W-1:0]    r_fail_pos;
   logic [CNT_W-1:0]    r_fail_neg;
   logic [1:0]          r_fail_flag;
   logic                r_busy;
   logic [SNAP_W-1:0]   r_sr;
   logic                r_sdo;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_async = {spo_neg_i, spo_pos_i, di_i, we_i, wclk_i};

   for (genvar g = 0; g < N_ASYNC; g++) begin : g_sync
      lutram_sync_bit #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .d_i    (w_async[g]),
         .q_o    (w_synced[g])
      );
   end

   assign w_wclk_s    = w_synced[0];
   assign w_we_s      = w_synced[1];
   assign w_di_s      = w_synced[2];
   assign w_spo_pos_s = w_synced[3];
   assign w_spo_neg_s = w_synced[4];

   assign w_rise = w_wclk_s & ~r_wclk_d;
   assign w_fall = ~w_wclk_s & r_wclk_d;

   // Expectation tracking, settle/check sequencing and saturating result counters.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wclk_d     <= 1'b0;
         r_state      <= ST_IDLE;
         r_target     <= TGT_POS;
         r_settle_cnt <= '0;
         r_exp_pos    <= INIT_VAL;
         r_exp_neg    <= INIT_VAL;
         r_chk_pos    <= '0;
         r_chk_neg    <= '0;
         r_fail_pos   <= '0;
         r_fail_neg   <= '0;
         r_fail_flag  <= 2'b00;
         r_busy       <= 1'b0;
      end else begin
         r_wclk_d <= w_wclk_s;
         if (clear_i) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_exp_pos   <= INIT_VAL;
            r_exp_neg   <= INIT_VAL;
            r_chk_pos   <= '0;
            r_chk_neg   <= '0;
            r_fail_pos  <= '0;
            r_fail_neg  <= '0;
            r_fail_flag <= 2'b00;
         end else if (w_rise || w_fall) begin
            // A new edge always wins; any check still in flight is dropped uncounted.
            if (w_we_s) begin
               if (w_rise) r_exp_pos <= w_di_s;
               else        r_exp_neg <= w_di_s;
            end
            r_target     <= w_rise ? TGT_POS : TGT_NEG;
            r_settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
            r_state      <= ST_SETTLE;
            r_busy       <= 1'b1;
         end else begin
            case (r_state)
               ST_SETTLE: begin
                  if (r_settle_cnt == '0) r_state <= ST_CHECK;
                  else                    r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
               end
               ST_CHECK: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  if (r_target == TGT_POS) begin
                     r_chk_pos <= sat_inc(r_chk_pos);
                     if (w_spo_pos_s != r_exp_pos) begin
                        r_fail_pos     <= sat_inc(r_fail_pos);
                        r_fail_flag[0] <= 1'b1;
                     end
                  end else begin
                     r_chk_neg <= sat_inc(r_chk_neg);
                     if (w_spo_neg_s != r_exp_neg) begin
                        r_fail_neg     <= sat_inc(r_fail_neg);
                        r_fail_flag[1] <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      w_snap = '0;
      w_snap[SNAP_CHK_POS*CNT_W  +: CNT_W] = r_chk_pos;
      w_snap[SNAP_CHK_NEG*CNT_W  +: CNT_W] = r_chk_neg;
      w_snap[SNAP_FAIL_POS*CNT_W +: CNT_W] = r_fail_pos;
      w_snap[SNAP_FAIL_NEG*CNT_W +: CNT_W] = r_fail_neg;
   end

   // Snapshot shift register; r_sdo mirrors the bit that lands in sr[0].
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_sr  <= '0;
         r_sdo <= 1'b0;
      end else if (cap_i) begin
         r_sr  <= w_snap;
         r_sdo <= w_snap[0];
      end else if (shift_i) begin
         r_sr  <= {sdi_i, r_sr[SNAP_W-1:1]};
         r_sdo <= r_sr[1];
      end
   end

   assign sdo_o  = r_sdo;
   assign fail_o = r_fail_flag;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_lutram_edge_checker.sv
// Randomized self-checking bench for lutram_edge_checker against a transaction-level
// model of the expected RAM contents and check/fail tallies.
module tb_lutram_edge_checker;

   logic       clk = 1'b0;
   logic       rst_n, wclk, we, di, spo_pos, spo_neg, clear, cap, shift, sdi;
   logic       sdo, busy;
   logic [1:0] fail;

   int n_err = 0;
   int n_chk = 0;

   // Reference model: unsaturated tallies, sticky flags, expected RAM bits.
   int m_chk_pos, m_chk_neg, m_fail_pos, m_fail_neg;
   bit m_flag_pos, m_flag_neg, m_exp_pos, m_exp_neg;

   always #5 clk = ~clk;

   lutram_edge_checker #(
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (4),
      .CNT_W         (8),
      .INIT_VAL      (1'b0)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .wclk_i    (wclk),
      .we_i      (we),
      .di_i      (di),
      .spo_pos_i (spo_pos),
      .spo_neg_i (spo_neg),
      .clear_i   (clear),
      .cap_i     (cap),
      .shift_i   (shift),
      .sdi_i     (sdi),
      .sdo_o     (sdo),
      .fail_o    (fail),
      .busy_o    (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic logic [31:0] model_snap();
      return {8'(sat(m_fail_neg)), 8'(sat(m_fail_pos)), 8'(sat(m_chk_neg)), 8'(sat(m_chk_pos))};
   endfunction

   task automatic model_clear();
      m_chk_pos = 0; m_chk_neg = 0; m_fail_pos = 0; m_fail_neg = 0;
      m_flag_pos = 0; m_flag_neg = 0; m_exp_pos = 0; m_exp_neg = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One wclk toggle. A checked edge is left alone long enough to be compared;
   // an unchecked one is followed by another edge two cycles later.
   task automatic do_edge(input bit nwe, input bit ndi, input bit corrupt, input bit checked);
      if (nwe !== we || ndi !== di) begin
         we = nwe;
         di = ndi;
         cycles(4);
      end
      wclk = ~wclk;
      if (wclk) begin
         if (we) m_exp_pos = di;
         spo_pos = m_exp_pos ^ corrupt;
         spo_neg = m_exp_neg;
      end else begin
         if (we) m_exp_neg = di;
         spo_neg = m_exp_neg ^ corrupt;
         spo_pos = m_exp_pos;
      end
      if (checked) begin
         cycles(14);
         if (wclk) begin
            m_chk_pos++;
            if (corrupt) begin m_fail_pos++; m_flag_pos = 1; end
         end else begin
            m_chk_neg++;
            if (corrupt) begin m_fail_neg++; m_flag_neg = 1; end
         end
         check("busy_after_check", 32'(busy), 32'd0);
         check("fail_o", 32'(fail), {30'd0, m_flag_neg, m_flag_pos});
      end else begin
         cycles(2);
      end
   endtask

   task automatic read_snap(output logic [31:0] v);
      cap = 1'b1;
      @(posedge clk); #1;
      cap = 1'b0;
      @(negedge clk);
      v[0] = sdo;
      for (int i = 1; i < 32; i++) begin
         shift = 1'b1;
         sdi   = 1'($urandom);
         @(posedge clk); #1;
         shift = 1'b0;
         @(negedge clk);
         v[i] = sdo;
      end
      #1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] snap;
      int          k;
      bit          rwe, rdi, rcor;

      rst_n = 0; wclk = 0; we = 0; di = 0; spo_pos = 0; spo_neg = 0;
      clear = 0; cap = 0; shift = 0; sdi = 0;
      model_clear();
      cycles(3);
      rst_n = 1;

      // Idle after reset: nothing counted, nothing flagged.
      cycles(50);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_fail", 32'(fail), 32'd0);
      read_snap(snap);
      check("reset_snap", snap, 32'd0);

      // Passing writes on both edges.
      do_edge(1, 1, 0, 1);
      do_edge(1, 1, 0, 1);
      read_snap(snap);
      check("pass_snap", snap, 32'h0000_0101);

      // Failing negedge write, then sticky flag survives passing checks.
      do_edge(1, 1, 0, 1);
      do_edge(1, 1, 1, 1);
      check("neg_fail_flag", 32'(fail), 32'd2);
      do_edge(1, 0, 0, 1);
      do_edge(1, 0, 0, 1);
      check("flag_sticky", 32'(fail), 32'd2);

      // Edge abandoned by a quick follow-up edge.
      clear = 1; cycles(1); clear = 0; model_clear();
      do_edge(1, 1, 0, 0);
      do_edge(1, 1, 0, 1);
      read_snap(snap);
      check("abandon_snap", snap, model_snap());

      // Randomized write/check traffic.
      for (int n = 0; n < 80; n++) begin
         rwe  = ($urandom % 4) != 0;
         rdi  = 1'($urandom);
         rcor = ($urandom % 4) == 0;
         if ($urandom % 3 == 0) begin
            do_edge(rwe, rdi, 1'($urandom), 0);
            do_edge(rwe, rdi, rcor, 1);
         end else begin
            do_edge(rwe, rdi, rcor, 1);
         end
      end
      read_snap(snap);
      check("random_snap", snap, model_snap());

      // Clear wipes counters and flags.
      clear = 1; cycles(1); clear = 0; model_clear();
      check("clear_fail", 32'(fail), 32'd0);
      read_snap(snap);
      check("clear_snap", snap, 32'd0);

      // Saturation: 300 failing posedge checks, negedges always abandoned.
      for (int n = 0; n < 300; n++) begin
         if (wclk) do_edge(1, 1, 0, 0);
         do_edge(1, 1, 1, 1);
      end
      read_snap(snap);
      check("sat_snap", snap, 32'h00FF_00FF);
      check("sat_model", snap, model_snap());
      check("sat_fail", 32'(fail), 32'd1);

      // Reset while a falling-edge check is settling.
      if (!wclk) do_edge(we, di, 0, 1);
      wclk = 1'b0;
      k = 0;
      while (!busy && k < 20) begin
         cycles(1);
         k++;
      end
      check("busy_seen", 32'(busy), 32'd1);
      rst_n = 0;
      cycles(1);
      rst_n = 1;
      model_clear();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fail", 32'(fail), 32'd0);
      cycles(20);
      check("rst_busy_later", 32'(busy), 32'd0);
      read_snap(snap);
      check("rst_snap", snap, model_snap());

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
